// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
// Request/response bundle for the bit-serial add/subtract sequencer.
//   start, sub, in1, in2  : request side, driven by the requester (master)
//   busy, done            : status, driven by the sequencer (slave)
//   sum, cOut, overflow   : result, driven by the sequencer, held until the
//                           next accepted request
// Parameter WIDTH sets operand/result width and must match the sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cOut;
  logic             overflow;

  modport master (
    output start, sub, in1, in2,
    input  busy, done, sum, cOut, overflow
  );

  modport slave (
    input  start, sub, in1, in2,
    output busy, done, sum, cOut, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial add/subtract sequencer. A single FullAdder is time-multiplexed
// over the operand bits, LSB first, one bit per clock. A request accepted at
// edge E0 raises busy for WIDTH cycles and pulses done in the cycle after
// edge E0+WIDTH, with sum/cOut/overflow valid from that cycle onward.
//
// Ports:
//   clk   : rising-edge clock
//   rstN  : synchronous, active-low reset
//   bus   : serial_adder_ctrl_if.slave (start, sub, in1, in2 in;
//           busy, done, sum, cOut, overflow out)
// Parameter WIDTH (default 32) must be at least 2.
//
// Build option: define SERIAL_ADDER_OVERFLOW_EN to compute signed overflow
// (carry into MSB XOR carry out). Without it overflow is tied to 0 and the
// carry-into-MSB register is not built.

// One-bit full adder shared across all bit positions.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rstN,
  serial_adder_ctrl_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_reg_q, a_reg_d;
  logic [WIDTH-1:0] b_reg_q, b_reg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             c_out_q, c_out_d;
  logic             fa_sum;
  logic             fa_carry;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             carry_into_msb_q, carry_into_msb_d;
  logic             overflow_q, overflow_d;
`endif

  FullAdder u_full_adder (
    .a     (a_reg_q[0]),
    .b     (b_reg_q[0]),
    .c_in  (carry_q),
    .s     (fa_sum),
    .c_out (fa_carry)
  );

  // Next-state logic. The edge that processes the MSB also loads the output
  // registers, so results are already valid during the DONE cycle.
  always_comb begin
    state_d   = state_q;
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    result_d  = result_q;
    sum_d     = sum_q;
    bit_cnt_d = bit_cnt_q;
    carry_d   = carry_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    c_out_d   = c_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    carry_into_msb_d = carry_into_msb_q;
    overflow_d       = overflow_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_reg_d   = bus.in1;
          b_reg_d   = bus.sub ? ~bus.in2 : bus.in2;
          carry_d   = bus.sub;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        result_d  = {fa_sum, result_q[WIDTH-1:1]};
        carry_d   = fa_carry;
        a_reg_d   = a_reg_q >> 1;
        b_reg_d   = b_reg_q >> 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (bit_cnt_q == PRE_MSB) begin
          carry_into_msb_d = fa_carry;
        end
`endif
        if (bit_cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, result_q[WIDTH-1:1]};
          c_out_d = fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          overflow_d = carry_into_msb_q ^ fa_carry;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= IDLE;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      result_q  <= '0;
      sum_q     <= '0;
      bit_cnt_q <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_out_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      carry_into_msb_q <= 1'b0;
      overflow_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      result_q  <= result_d;
      sum_q     <= sum_d;
      bit_cnt_q <= bit_cnt_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_out_q   <= c_out_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      carry_into_msb_q <= carry_into_msb_d;
      overflow_q       <= overflow_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cOut = c_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl: directed corner cases, a
// start pulse mid-operation, reset mid-operation, back-to-back requests and
// randomized add/subtract operations compared with an arithmetic model.
// Honours SERIAL_ADDER_OVERFLOW_EN for the expected overflow flag.
module tb_serial_adder_ctrl;
  localparam int W = 32;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   overlap_cnt  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // busy and done must never be high in the same cycle.
  always @(negedge clk) begin
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: plain modular arithmetic and signed range test.
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, output logic [W-1:0] r,
                                   output logic co, output logic ov);
    logic [W:0] full;
    longint     sa, sb, sres, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) <<< (W - 1);
    if (s) begin
      full = {1'b0, a} - {1'b0, b};
      co   = (a >= b);
      sres = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b};
      co   = full[W];
      sres = sa + sb;
    end
    r = full[W-1:0];
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ov = (sres >= lim) || (sres < -lim);
`else
    ov = 1'b0;
`endif
  endfunction

  // Runs one operation from IDLE. inject = 1 pulses start with fresh
  // operands in the middle of the run; it must be ignored.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input int inject);
    logic [W-1:0] er;
    logic         ec, eo;
    int           n, busy_n;
    refModel(a, b, s, er, ec, eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    bus.sub   = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
    bus.sub   = 1'($urandom);
    n      = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && n <= W + 4) begin
      if (bus.busy === 1'b1) busy_n++;
      if (inject == 1 && n == 11) begin
        bus.start = 1'b1;
        bus.in1   = $urandom;
        bus.in2   = $urandom;
        bus.sub   = ~s;
      end
      if (inject == 1 && n == 12) bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    checkOutput("done_latency", 64'(n), 64'(W + 1));
    checkOutput("busy_cycles", 64'(busy_n), 64'(W));
    checkOutput("sum", 64'(bus.sum), 64'(er));
    checkOutput("cOut", 64'(bus.cOut), 64'(ec));
    checkOutput("overflow", 64'(bus.overflow), 64'(eo));
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(bus.done), 64'(0));
    checkOutput("busy_after_done", 64'(bus.busy), 64'(0));
    checkOutput("sum_held", 64'(bus.sum), 64'(er));
  endtask

  initial begin
    int n, first, saw_done;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(bus.busy), 64'(0));
    checkOutput("reset_done", 64'(bus.done), 64'(0));
    checkOutput("reset_sum", 64'(bus.sum), 64'(0));
    checkOutput("reset_cOut", 64'(bus.cOut), 64'(0));
    checkOutput("reset_overflow", 64'(bus.overflow), 64'(0));
    rstN = 1'b1;

    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 0);

    // Reset in the middle of a run: everything clears, no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'hDEAD_BEEF;
    bus.in2   = 32'h0123_4567;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("midrun_reset_busy", 64'(bus.busy), 64'(0));
    checkOutput("midrun_reset_done", 64'(bus.done), 64'(0));
    checkOutput("midrun_reset_sum", 64'(bus.sum), 64'(0));
    checkOutput("midrun_reset_cOut", 64'(bus.cOut), 64'(0));
    checkOutput("midrun_reset_overflow", 64'(bus.overflow), 64'(0));
    saw_done = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1;
    end
    checkOutput("midrun_reset_quiet", 64'(saw_done), 64'(0));
    applyStimulus(32'h0000_0002, 32'h0000_0002, 1'b0, 0);

    // start held high: two operations at the maximum rate.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'h1;
    bus.in2   = 32'h1;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.in1 = 32'h3;
    bus.in2 = 32'h4;
    n = 1;
    while (bus.done !== 1'b1 && n <= W + 4) begin
      @(negedge clk);
      n++;
    end
    first = n;
    checkOutput("b2b_first_sum", 64'(bus.sum), 64'(2));
    @(negedge clk);
    n++;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && n <= first + W + 6) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_done_gap", 64'(n - first), 64'(W + 2));
    checkOutput("b2b_second_sum", 64'(bus.sum), 64'(7));
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ra;
      applyStimulus(ra, rb, 1'($urandom), (i % 5 == 0) ? 1 : 0);
    end

    checkOutput("busy_done_overlap", 64'(overlap_cnt), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
